ex_mem_skid: RTL

EX_MEM_SKID -- requirements
Module: ex_mem_skid

---
 rtl/cpu_pkg.sv | 31 +++
 rtl/pipe_slot.sv | 31 +++
 rtl/ex_mem_skid.sv | 118 +++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU pipeline definitions: EX/MEM register defaults, control-bit
// layout and the capture-time control sanitiser.
package cpu_pkg;

    localparam int unsigned EXMEM_DATA_W = 32;
    localparam int unsigned EXMEM_REG_W  = 5;

    // Bit positions inside the 4-bit EX/MEM control word
    localparam int unsigned CTRL_REGW = 3;
    localparam int unsigned CTRL_MEMR = 2;
    localparam int unsigned CTRL_MEMW = 1;
    localparam int unsigned CTRL_M2R  = 0;

    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic mem_to_reg;
    } exmem_ctrl_t;

    // A write to r0 is architecturally a no-op, so reg_write is dropped at capture.
    function automatic exmem_ctrl_t capture_ctrl(input logic [3:0] ctrl, input logic rd_zero);
        exmem_ctrl_t c;
        c = exmem_ctrl_t'(ctrl);
        if (rd_zero) begin
            c.reg_write = 1'b0;
        end
        return c;
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// One pipeline slot: valid bit plus payload register with load and clear.
// Clear wins over load for the valid bit; payload changes only on load.
module pipe_slot #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic         valid,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            q     <= '0;
        end else begin
            if (clr) begin
                valid <= 1'b0;
            end else if (load) begin
                valid <= 1'b1;
            end
            if (load) begin
                q <= d;
            end
        end
    end

endmodule

// File: rtl/ex_mem_skid.sv
// EX/MEM pipeline register with a one-entry skid buffer so ex_ready is a pure flop.
// Optional forwarding outputs are built when EXMEM_FWD_EN is defined.
module ex_mem_skid
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W = EXMEM_DATA_W,
    parameter int unsigned REG_W  = EXMEM_REG_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [DATA_W-1:0] ex_alu_res,
    input  logic [DATA_W-1:0] ex_st_data,
    input  logic [REG_W-1:0]  ex_rd,
    input  logic [3:0]        ex_ctrl,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [DATA_W-1:0] mem_alu_res,
    output logic [DATA_W-1:0] mem_st_data,
    output logic [REG_W-1:0]  mem_rd,
    output logic [3:0]        mem_ctrl
`ifdef EXMEM_FWD_EN
    ,
    output logic              fwd_valid,
    output logic [REG_W-1:0]  fwd_rd,
    output logic [DATA_W-1:0] fwd_data
`endif
);

    localparam int unsigned PW = 2 * DATA_W + REG_W + 4;

    exmem_ctrl_t   cap_ctrl;
    logic [PW-1:0] ex_pl;
    logic [PW-1:0] main_d;
    logic [PW-1:0] main_q;
    logic [PW-1:0] skid_q;
    logic          main_valid;
    logic          skid_valid;
    logic          acc;
    logic          ret;
    logic          main_load;
    logic          main_clr;
    logic          skid_load;
    logic          skid_clr;

    assign cap_ctrl = capture_ctrl(ex_ctrl, ex_rd == '0);
    assign ex_pl    = {ex_alu_res, ex_st_data, ex_rd, cap_ctrl};

    assign ex_ready = ~skid_valid;
    assign acc      = ex_valid & ex_ready;
    assign ret      = main_valid & mem_ready;

    // Skid refills main on retire; an accept can only coincide when skid is empty.
    always_comb begin
        main_load = 1'b0;
        main_clr  = 1'b0;
        skid_load = 1'b0;
        skid_clr  = 1'b0;
        main_d    = ex_pl;
        if (flush) begin
            main_clr = 1'b1;
            skid_clr = 1'b1;
        end else begin
            if (skid_valid) begin
                main_d = skid_q;
                if (ret) begin
                    main_load = 1'b1;
                    skid_clr  = 1'b1;
                end
            end else if (acc) begin
                if (!main_valid || ret) begin
                    main_load = 1'b1;
                end else begin
                    skid_load = 1'b1;
                end
            end
            if (ret && !main_load) begin
                main_clr = 1'b1;
            end
        end
    end

    pipe_slot #(
        .W (PW)
    ) u_main (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (main_clr),
        .load  (main_load),
        .d     (main_d),
        .valid (main_valid),
        .q     (main_q)
    );

    pipe_slot #(
        .W (PW)
    ) u_skid (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (skid_clr),
        .load  (skid_load),
        .d     (ex_pl),
        .valid (skid_valid),
        .q     (skid_q)
    );

    assign mem_valid = main_valid;
    assign {mem_alu_res, mem_st_data, mem_rd, mem_ctrl} = main_q;

`ifdef EXMEM_FWD_EN
    assign fwd_valid = mem_valid & mem_ctrl[CTRL_REGW] & ~mem_ctrl[CTRL_MEMR];
    assign fwd_rd    = mem_rd;
    assign fwd_data  = mem_alu_res;
`endif

endmodule
